// File: rtl/note_sequencer.sv
// Note sequencer: buffers received note bytes in a FIFO and plays each one
// for (dur+1) beats followed by a silent gap, driving a registered note code.
module note_sequencer #(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clear,
  output logic [4:0] note,
  output logic       playing,
  output logic [4:0] fifo_count,
  output logic       overflow
);

  localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_SPAN = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
  localparam int CW       = (CNT_SPAN > 2) ? $clog2(CNT_SPAN) : 1;
  localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [4:0]    DEPTH     = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  state_t        state;
  logic [2:0]    dur, beat;
  logic [CW-1:0] cyc;

  logic       full, push, drop, pop;
  logic [7:0] head;

  // Full check uses the pre-edge count, so a byte arriving on a pop edge while full is dropped.
  always_comb begin
    full = (count == DEPTH);
    push = rx_valid && !clear && !full;
    drop = rx_valid && !clear && full;
    pop  = (state == IDLE) && (count != '0) && !clear;
    head = mem[rd_ptr];
  end

  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      note    <= '0;
      playing <= 1'b0;
      dur     <= '0;
      beat    <= '0;
      cyc     <= '0;
    end else if (clear) begin
      state   <= IDLE;
      note    <= '0;
      playing <= 1'b0;
      dur     <= '0;
      beat    <= '0;
      cyc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            dur     <= head[7:5];
            beat    <= '0;
            cyc     <= '0;
            note    <= (head[4:0] <= 5'd21) ? head[4:0] : '0;
            playing <= 1'b1;
            state   <= PLAY;
          end else begin
            note    <= '0;
            playing <= 1'b0;
          end
        end
        PLAY: begin
          if (cyc == BEAT_LAST) begin
            cyc <= '0;
            if (beat == dur) begin
              note <= '0;
              if (GAP_CYCLES > 0) begin
                state <= GAP;
              end else begin
                state   <= IDLE;
                playing <= 1'b0;
              end
            end else begin
              beat <= beat + 3'd1;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        GAP: begin
          if (cyc == GAP_LAST) begin
            cyc     <= '0;
            state   <= IDLE;
            playing <= 1'b0;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus random traffic, checked
// against a timeline model that expands each popped byte into per-cycle outputs.
module tb_note_sequencer;

  localparam int BEAT  = 4;
  localparam int GAPC  = 2;
  localparam int DEPTH = 4;

  logic       clk, rst, rx_valid, clear;
  logic [7:0] rx_data;
  logic [4:0] note, fifo_count;
  logic       playing, overflow;

  note_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .clear(clear),
    .note(note), .playing(playing), .fifo_count(fifo_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model: queue of buffered bytes, and a timeline of {note, playing} for upcoming cycles.
  logic [7:0] q[$];
  logic [5:0] tl[$];
  logic       m_ovf;
  logic [4:0] exp_note, exp_cnt;
  logic       exp_play;

  task automatic model_reset();
    q.delete();
    tl.delete();
    m_ovf    = 1'b0;
    exp_note = '0;
    exp_play = 1'b0;
    exp_cnt  = '0;
  endtask

  task automatic tick(input logic v, input logic [7:0] d, input logic c);
    int         pre;
    logic [7:0] b;
    logic [4:0] n;
    logic [5:0] e;
    rx_valid = v;
    rx_data  = d;
    clear    = c;
    @(posedge clk);
    if (c) begin
      q.delete();
      tl.delete();
      m_ovf = 1'b0;
    end else begin
      pre = q.size();
      if (tl.size() == 0 && pre > 0) begin
        b = q.pop_front();
        n = (b[4:0] <= 5'd21) ? b[4:0] : 5'd0;
        repeat ((int'(b[7:5]) + 1) * BEAT) tl.push_back({n, 1'b1});
        repeat (GAPC) tl.push_back({5'd0, 1'b1});
        tl.push_back({5'd0, 1'b0});
      end
      if (v) begin
        if (pre < DEPTH) q.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    if (tl.size() > 0) e = tl.pop_front();
    else e = 6'd0;
    exp_note = e[5:1];
    exp_play = e[0];
    exp_cnt  = 5'(q.size());
    #1;
    rx_valid = 1'b0;
    clear    = 1'b0;
    rx_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; clear = 1'b0; rx_data = '0;
    model_reset();
    #3;
    checks++;
    if ({note, playing, fifo_count, overflow} !== 12'd0)
      begin fails++; $display("FAIL reset_async: note=%0d play=%0b cnt=%0d ovf=%0b, expected all 0", note, playing, fifo_count, overflow); end
    @(negedge clk);
    rst = 1'b0;
    tick(1'b0, 8'h00, 1'b0);
    checks++;
    if ({note, playing, fifo_count, overflow} !== 12'd0)
      begin fails++; $display("FAIL reset_idle: note=%0d play=%0b cnt=%0d ovf=%0b, expected all 0", note, playing, fifo_count, overflow); end
  endtask

  task automatic test_single_note();
    logic [5:0] want;
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h28, 1'b0);
    checks++;
    if (fifo_count !== 5'd1 || playing !== 1'b0)
      begin fails++; $display("FAIL single_push: cnt=%0d play=%0b, expected cnt=1 play=0", fifo_count, playing); end
    for (int k = 1; k <= 12; k++) begin
      tick(1'b0, 8'h00, 1'b0);
      want = (k <= 8) ? {5'd8, 1'b1} : (k <= 10) ? {5'd0, 1'b1} : {5'd0, 1'b0};
      checks++;
      if ({note, playing} !== want)
        begin fails++; $display("FAIL single_note T+%0d: note=%0d play=%0b, expected note=%0d play=%0b", k, note, playing, want[5:1], want[0]); end
      checks++;
      if ({note, playing, fifo_count, overflow} !== {exp_note, exp_play, exp_cnt, m_ovf})
        begin fails++; $display("FAIL single_model T+%0d: note=%0d play=%0b cnt=%0d ovf=%0b, expected %0d %0b %0d %0b", k, note, playing, fifo_count, overflow, exp_note, exp_play, exp_cnt, m_ovf); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [6];
    bytes = '{8'h01, 8'h22, 8'h03, 8'h44, 8'h05, 8'h06};
    tick(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, bytes[i], 1'b0);
      checks++;
      if ({note, playing, fifo_count, overflow} !== {exp_note, exp_play, exp_cnt, m_ovf})
        begin fails++; $display("FAIL overflow_fill %0d: note=%0d play=%0b cnt=%0d ovf=%0b, expected %0d %0b %0d %0b", i, note, playing, fifo_count, overflow, exp_note, exp_play, exp_cnt, m_ovf); end
    end
    checks++;
    if (fifo_count !== 5'd4 || overflow !== 1'b1)
      begin fails++; $display("FAIL overflow_flag: cnt=%0d ovf=%0b, expected cnt=4 ovf=1", fifo_count, overflow); end
    for (int k = 0; k < 60; k++) begin
      tick(1'b0, 8'h00, 1'b0);
      checks++;
      if ({note, playing, fifo_count, overflow} !== {exp_note, exp_play, exp_cnt, m_ovf})
        begin fails++; $display("FAIL overflow_play %0d: note=%0d play=%0b cnt=%0d ovf=%0b, expected %0d %0b %0d %0b", k, note, playing, fifo_count, overflow, exp_note, exp_play, exp_cnt, m_ovf); end
    end
  endtask

  task automatic test_invalid_code();
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h19, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 8'h00, 1'b0);
      checks++;
      if ({note, playing} !== {5'd0, (k <= 6)})
        begin fails++; $display("FAIL invalid_code T+%0d: note=%0d play=%0b, expected note=0 play=%0b", k, note, playing, (k <= 6)); end
    end
  endtask

  task automatic test_clear();
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h48, 1'b0);
    tick(1'b1, 8'h21, 1'b0);
    tick(1'b1, 8'h22, 1'b0);
    tick(1'b1, 8'h23, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    checks++;
    if (fifo_count !== 5'd3 || note !== 5'd8)
      begin fails++; $display("FAIL clear_pre: cnt=%0d note=%0d, expected cnt=3 note=8", fifo_count, note); end
    tick(1'b1, 8'h05, 1'b1);
    checks++;
    if ({note, playing, fifo_count, overflow} !== 12'd0)
      begin fails++; $display("FAIL clear_flush: note=%0d play=%0b cnt=%0d ovf=%0b, expected all 0", note, playing, fifo_count, overflow); end
    tick(1'b0, 8'h00, 1'b0);
    checks++;
    if ({note, playing, fifo_count, overflow} !== 12'd0)
      begin fails++; $display("FAIL clear_after: note=%0d play=%0b cnt=%0d ovf=%0b, expected all 0", note, playing, fifo_count, overflow); end
  endtask

  task automatic test_back_to_back();
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b1, 8'h0B, 1'b0);
    tick(1'b1, 8'h0C, 1'b0);
    tick(1'b1, 8'h0D, 1'b0);
    tick(1'b1, 8'h0E, 1'b0);
    repeat (3) tick(1'b0, 8'h00, 1'b0);
    checks++;
    if ({note, playing, fifo_count, overflow} !== {5'd0, 1'b0, 5'd4, 1'b0})
      begin fails++; $display("FAIL b2b_idle: note=%0d play=%0b cnt=%0d ovf=%0b, expected 0 0 4 0", note, playing, fifo_count, overflow); end
    tick(1'b1, 8'h0F, 1'b0);
    checks++;
    if ({note, playing, fifo_count, overflow} !== {5'd11, 1'b1, 5'd3, 1'b1})
      begin fails++; $display("FAIL b2b_full_pop: note=%0d play=%0b cnt=%0d ovf=%0b, expected 11 1 3 1", note, playing, fifo_count, overflow); end
    for (int k = 0; k < 30; k++) begin
      tick(1'b0, 8'h00, 1'b0);
      checks++;
      if ({note, playing, fifo_count, overflow} !== {exp_note, exp_play, exp_cnt, m_ovf})
        begin fails++; $display("FAIL b2b_model %0d: note=%0d play=%0b cnt=%0d ovf=%0b, expected %0d %0b %0d %0b", k, note, playing, fifo_count, overflow, exp_note, exp_play, exp_cnt, m_ovf); end
    end
  endtask

  task automatic test_reset_gap();
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h02, 1'b0);
    repeat (5) tick(1'b0, 8'h00, 1'b0);
    checks++;
    if ({note, playing} !== {5'd0, 1'b1})
      begin fails++; $display("FAIL rstgap_in_gap: note=%0d play=%0b, expected note=0 play=1", note, playing); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({note, playing, fifo_count, overflow} !== 12'd0)
      begin fails++; $display("FAIL rstgap_abort: note=%0d play=%0b cnt=%0d ovf=%0b, expected all 0", note, playing, fifo_count, overflow); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(1'b1, 8'h01, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick(1'b0, 8'h00, 1'b0);
      checks++;
      if ({note, playing} !== ((k <= 4) ? {5'd1, 1'b1} : {5'd0, 1'b1}))
        begin fails++; $display("FAIL rstgap_resume T+%0d: note=%0d play=%0b, expected note=%0d play=1", k, note, playing, (k <= 4) ? 1 : 0); end
    end
  endtask

  task automatic test_random();
    logic       v, c;
    logic [7:0] d;
    tick(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 3000; k++) begin
      v = ($urandom_range(0, 99) < 35);
      c = ($urandom_range(0, 299) == 0);
      d = 8'($urandom);
      tick(v, d, c);
      checks++;
      if ({note, playing, fifo_count, overflow} !== {exp_note, exp_play, exp_cnt, m_ovf})
        begin fails++; $display("FAIL random %0d: note=%0d play=%0b cnt=%0d ovf=%0b, expected %0d %0b %0d %0b", k, note, playing, fifo_count, overflow, exp_note, exp_play, exp_cnt, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_overflow();
    test_invalid_code();
    test_clear();
    test_back_to_back();
    test_reset_gap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
